// File: rtl/acc_core_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator core: drives the program
// address, latches the instruction and issues registered one-cycle execute strobes.
module acc_core_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 63
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             clear,
  input  logic             pause,
  input  logic [7:0]       instr,
  input  logic             cb,
  input  logic             alu_done,
  output logic [3:0]       pc,
  output logic [7:0]       ir,
  output logic             alu_go,
  output logic             acc_ld,
  output logic             rf_we,
  output logic             halted,
  output logic             err_timeout,
  output logic             err_illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);
  localparam int unsigned WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            st;
  logic [WCNT_W-1:0] wcnt;
  logic [3:0]        op_hi;
  logic              dec_nop, dec_hlt, dec_ill, dec_br, dec_ret;
  logic              dec_acc, dec_rf, dec_mul, dec_alu;

  assign state = st;
  assign op_hi = ir[7:4];

  // Opcode decode of the latched instruction
  always_comb begin
    dec_nop = (ir == 8'h00);
    dec_hlt = (ir == 8'hFF);
    dec_ill = ((op_hi == 4'h0) && ir[3]) || ((op_hi >= 4'hC) && !dec_hlt);
    dec_br  = (op_hi == 4'h8);
    dec_acc = (op_hi == 4'h9);
    dec_rf  = (op_hi == 4'hA);
    dec_ret = (op_hi == 4'hB);
    dec_mul = (op_hi == 4'h3) || (op_hi == 4'h4);
    dec_alu = (op_hi <= 4'h7) && !dec_nop && !dec_ill;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st          <= S_IDLE;
      pc          <= 4'd0;
      ir          <= 8'd0;
      alu_go      <= 1'b0;
      acc_ld      <= 1'b0;
      rf_we       <= 1'b0;
      halted      <= 1'b0;
      err_timeout <= 1'b0;
      err_illegal <= 1'b0;
      retired     <= '0;
      wcnt        <= '0;
    end else begin
      alu_go <= 1'b0;
      acc_ld <= 1'b0;
      rf_we  <= 1'b0;
      if (clear) begin
        st          <= S_IDLE;
        pc          <= 4'd0;
        halted      <= 1'b0;
        err_timeout <= 1'b0;
        err_illegal <= 1'b0;
        retired     <= '0;
        wcnt        <= '0;
      end else if (!pause) begin
        case (st)
          S_IDLE: begin
            pc <= 4'd0;
            if (run) st <= S_FETCH;
          end
          S_FETCH: begin
            ir <= instr;
            pc <= pc + 4'd1;
            st <= S_EXEC;
          end
          S_EXEC: begin
            alu_go <= dec_alu;
            acc_ld <= dec_acc;
            rf_we  <= dec_rf;
            if ((dec_br && cb) || dec_ret) pc <= ir[3:0];
            if (dec_ill) err_illegal <= 1'b1;
            if (dec_mul) begin
              st   <= S_WAIT;
              wcnt <= '0;
            end else begin
              retired <= retired + CNT_W'(1);
              if (dec_hlt) begin
                st     <= S_HALT;
                halted <= 1'b1;
              end else begin
                st <= S_FETCH;
              end
            end
          end
          S_WAIT: begin
            // A completion arriving on the last allowed cycle still wins
            if (alu_done) begin
              retired <= retired + CNT_W'(1);
              st      <= S_FETCH;
            end else begin
              wcnt <= wcnt + WCNT_W'(1);
              if (wcnt == WAIT_LAST) begin
                err_timeout <= 1'b1;
                halted      <= 1'b1;
                st          <= S_HALT;
              end
            end
          end
          S_HALT: halted <= 1'b1;
          default: st <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acc_core_sequencer.sv
// Randomized scoreboard bench for acc_core_sequencer against an instruction-level
// model of the accumulator core program flow.
module tb_acc_core_sequencer;
  localparam int unsigned CNT_W    = 16;
  localparam int          WAIT_MAX = 63;
  localparam int          K_MAX    = 24;

  logic             clk = 1'b0;
  logic             rstn, run, clear, pause, cb, alu_done;
  logic [7:0]       instr;
  logic [3:0]       pc;
  logic [7:0]       ir;
  logic             alu_go, acc_ld, rf_we, halted, err_timeout, err_illegal;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  logic [7:0]  mem [16];
  logic [10:0] sb[$];
  logic [10:0] sb_e;
  int          exp_wait[$];
  int          delays[$];
  int          errors = 0;
  int          checks = 0;

  assign instr = mem[pc];
  always #5 clk = ~clk;

  acc_core_sequencer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rstn(rstn), .run(run), .clear(clear), .pause(pause),
    .instr(instr), .cb(cb), .alu_done(alu_done), .pc(pc), .ir(ir),
    .alu_go(alu_go), .acc_ld(acc_ld), .rf_we(rf_we), .halted(halted),
    .err_timeout(err_timeout), .err_illegal(err_illegal),
    .retired(retired), .state(state)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int get_delay(input int i);
    return (i < delays.size()) ? delays[i] : 0;
  endfunction

  // Monitor: every strobe pulse must match the next expected {kind, instruction}
  always @(negedge clk) begin
    if (rstn && (alu_go || acc_ld || rf_we)) begin
      sb_e = (sb.size() > 0) ? sb.pop_front() : 11'h7FF;
      chk("strobe", int'({alu_go, acc_ld, rf_we, ir}), int'(sb_e));
    end
  end

  // Instruction-level reference: walks the program, queues strobes and wait lengths
  task automatic model(input logic cbv, output int r, output int p, output int lastop,
                       output bit h, output bit to, output bit il);
    logic [7:0] op;
    logic [3:0] hn;
    int di, d;
    r = 0; p = 0; lastop = 0; h = 0; to = 0; il = 0; di = 0;
    while (!h && r < K_MAX) begin
      op = mem[p];
      lastop = int'(op);
      p = (p + 1) % 16;
      hn = op[7:4];
      if (op == 8'hFF) begin r++; h = 1; end
      else if (op == 8'h00) r++;
      else if ((op >= 8'h08 && op <= 8'h0F) || op >= 8'hC0) begin il = 1; r++; end
      else if (hn == 4'h8) begin if (cbv) p = int'(op[3:0]); r++; end
      else if (hn == 4'hB) begin p = int'(op[3:0]); r++; end
      else if (hn == 4'h9) begin sb.push_back({3'b010, op}); r++; end
      else if (hn == 4'hA) begin sb.push_back({3'b001, op}); r++; end
      else begin
        sb.push_back({3'b100, op});
        if (hn == 4'h3 || hn == 4'h4) begin
          d = get_delay(di);
          di++;
          if (d == 0 || d > WAIT_MAX) begin
            to = 1; h = 1;
            exp_wait.push_back(WAIT_MAX);
          end else begin
            exp_wait.push_back(d);
            r++;
          end
        end else r++;
      end
    end
  endtask

  // Runs the loaded program until halt or K_MAX retirements, then clears
  task automatic run_prog(input logic cbv, input bit rnd_pause, input bit pause_exec,
                          input int exp_cycles);
    int er, ep, elast, n, di, wcnt, d, pleft, ew;
    bit eh, eto, eil, pdone, fin;
    logic [2:0] prev;
    sb.delete();
    exp_wait.delete();
    model(cbv, er, ep, elast, eh, eto, eil);
    n = 0; di = 0; wcnt = 0; d = 0; pleft = 0; pdone = 0; fin = 0; prev = 3'd0;
    cb = cbv;
    run = 1'b1;
    while (!fin && n < 4000) begin
      @(negedge clk);
      n++;
      if (prev == 3'd3 && state != 3'd3) begin
        ew = (exp_wait.size() > 0) ? exp_wait.pop_front() : -1;
        chk("wait_len", wcnt, ew);
      end
      if (state == 3'd3) begin
        if (prev != 3'd3) begin
          wcnt = 0;
          d = get_delay(di);
          di++;
        end
        wcnt++;
        alu_done = (d != 0) && (wcnt >= d);
      end else begin
        alu_done = 1'b0;
      end
      fin = halted || (int'(retired) == K_MAX);
      if (fin) pause = 1'b0;
      else if (pleft > 0) begin
        chk("pause_strobe", int'({alu_go, acc_ld, rf_we}), 0);
        chk("pause_state", int'(state), 2);
        pleft--;
        pause = (pleft > 0);
      end else if (pause_exec && !pdone && state == 3'd2 &&
                   (ir[7:4] inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7})) begin
        pause = 1'b1;
        pleft = 7;
        pdone = 1;
      end else begin
        pause = rnd_pause && (state != 3'd3) && ($urandom_range(0, 7) == 0);
      end
      prev = state;
    end
    chk("run_done", int'(fin), 1);
    if (exp_cycles > 0) chk("cycles", n, exp_cycles);
    if (pause_exec) chk("pause_applied", int'(pdone), 1);
    chk("halted", int'(halted), int'(eh));
    chk("err_timeout", int'(err_timeout), int'(eto));
    chk("err_illegal", int'(err_illegal), int'(eil));
    chk("retired", int'(retired), er);
    chk("pc", int'(pc), ep);
    chk("ir", int'(ir), elast);
    chk("state", int'(state), eh ? 4 : 1);
    clear = 1'b1; run = 1'b0; alu_done = 1'b0; pause = 1'b0;
    @(negedge clk);
    chk("clr_state", int'(state), 0);
    chk("clr_retired", int'(retired), 0);
    chk("clr_flags", int'({halted, err_timeout, err_illegal}), 0);
    chk("clr_pc", int'(pc), 0);
    chk("clr_ir_kept", int'(ir), elast);
    chk("sb_drained", sb.size(), 0);
    chk("wait_drained", exp_wait.size(), 0);
    sb.delete();
    exp_wait.delete();
    clear = 1'b0;
  endtask

  task automatic mem_zero();
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 15))
      0, 1, 2, 3, 4: return 8'($urandom_range(8'h10, 8'h7F));
      5:  return 8'($urandom_range(8'h80, 8'h8F));
      6:  return 8'($urandom_range(8'h90, 8'h9F));
      7:  return 8'($urandom_range(8'hA0, 8'hAF));
      8:  return 8'($urandom_range(8'hB0, 8'hBF));
      9:  return 8'h00;
      10: return 8'hFF;
      11: return 8'($urandom_range(8'hC0, 8'hFE));
      12: return 8'($urandom_range(8'h08, 8'h0F));
      13: return 8'($urandom_range(8'h01, 8'h07));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic int rand_delay();
    case ($urandom_range(0, 19))
      0: return 0;
      1: return WAIT_MAX;
      2: return WAIT_MAX + 1;
      default: return int'($urandom_range(1, 6));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0; run = 1'b0; clear = 1'b0; pause = 1'b0; cb = 1'b0; alu_done = 1'b0;
    mem_zero();
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_pc_ir", int'({pc, ir}), 0);
    chk("rst_outs", int'({alu_go, acc_ld, rf_we, halted, err_timeout, err_illegal}), 0);
    chk("rst_retired", int'(retired), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Straight-line program; one IDLE cycle precedes the 12 fetch/exec cycles
    mem[0] = 8'h91; mem[1] = 8'h61; mem[2] = 8'h15;
    mem[3] = 8'h16; mem[4] = 8'hA7; mem[5] = 8'hFF;
    run_prog(1'b0, 1'b0, 1'b0, 13);
    run_prog(1'b0, 1'b0, 1'b1, 20);

    mem_zero();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h8A; mem[3] = 8'hFF; mem[10] = 8'hFF;
    run_prog(1'b1, 1'b0, 1'b0, 0);
    run_prog(1'b0, 1'b0, 1'b0, 0);

    mem_zero();
    mem[0] = 8'h11; mem[1] = 8'hBF; mem[15] = 8'hB0;
    run_prog(1'b0, 1'b1, 1'b0, 0);

    mem_zero();
    mem[0] = 8'h32; mem[1] = 8'hFF;
    delays = '{5};
    run_prog(1'b0, 1'b0, 1'b0, 0);
    delays = '{0};
    run_prog(1'b0, 1'b0, 1'b0, 0);
    delays = '{WAIT_MAX};
    run_prog(1'b0, 1'b0, 1'b0, 0);
    delays = '{WAIT_MAX + 1};
    run_prog(1'b0, 1'b0, 1'b0, 0);

    mem_zero();
    mem[0] = 8'hC3; mem[1] = 8'h21; mem[2] = 8'hFF;
    run_prog(1'b0, 1'b0, 1'b0, 0);

    // clear together with run returns to IDLE with counters and flags wiped
    mem_zero();
    mem[0] = 8'hC3;
    run = 1'b1;
    n = 0;
    while (!err_illegal && n < 20) begin @(negedge clk); n++; end
    chk("illegal_seen", int'(err_illegal), 1);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk("clrrun_state", int'(state), 0);
    chk("clrrun_flags", int'({err_illegal, err_timeout, halted}), 0);
    chk("clrrun_retired", int'(retired), 0);
    clear = 1'b0; run = 1'b0;
    @(negedge clk);
    chk("clrrun_idle", int'(state), 0);

    // Reset asserted while the MUL strobe is high in the first WAIT cycle
    mem_zero();
    mem[0] = 8'h32; mem[1] = 8'hFF;
    sb.delete();
    sb.push_back({3'b100, 8'h32});
    run = 1'b1;
    n = 0;
    while (state != 3'd3 && n < 20) begin @(negedge clk); n++; end
    chk("reached_wait", int'(state), 3);
    rstn = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_strobes", int'({alu_go, acc_ld, rf_we}), 0);
    chk("arst_pc_ir", int'({pc, ir}), 0);
    chk("arst_retired", int'(retired), 0);
    run = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    sb.delete();
    mem[0] = 8'h91; mem[1] = 8'hFF;
    run_prog(1'b0, 1'b0, 1'b0, 5);

    for (int t = 0; t < 40; t++) begin
      for (int a = 0; a < 16; a++) mem[a] = rand_op();
      delays.delete();
      for (int i = 0; i < 32; i++) delays.push_back(rand_delay());
      run_prog(1'($urandom_range(0, 1)), 1'b1, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
